serial_feed_ctrl: RTL and testbench
===================================

SERIAL_FEED_CTRL -- requirements
Module: serial_feed_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits and the shift burst length in cycles (legal range 2..16).
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to load operands and begin a burst; sampled on the rising edge of clock.
REQ-005 The block SHALL have port hold, input, 1 bit: pause request during a burst.
REQ-006 The block SHALL have port a_in, input, WIDTH bits: operand A, parallel.
REQ-007 The block SHALL have port b_in, input, WIDTH bits: operand B, parallel.
REQ-008 The block SHALL have port shift_cont, output, 1 bit: shift enable to the downstream serial stage.
REQ-009 The block SHALL have port s_input_A, output, 1 bit: current serial bit of A, LSB first.
REQ-010 The block SHALL have port s_input, output, 1 bit: current serial bit of B, LSB first.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a burst is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-013 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with busy = (state == SHIFT) and done = (state == DONE).
REQ-014 In IDLE, start = 1 at a rising edge SHALL load a_in and b_in into internal shift registers, set the bit counter to WIDTH-1, and enter SHIFT.
REQ-015 start SHALL be ignored in SHIFT and DONE; operand inputs SHALL be don't-care outside the load edge.
REQ-016 shift_cont SHALL equal (state == SHIFT) && !hold, decoded combinationally from registered state.
REQ-017 s_input_A and s_input SHALL be bit 0 of the A and B shift registers, and SHALL read 0 in IDLE.
REQ-018 At each rising edge with shift_cont = 1, both registers SHALL shift right, filling with 0, and the counter SHALL decrement.
REQ-019 With hold = 1 in SHIFT, the registers, the counter and the state SHALL be frozen, and the serial outputs SHALL keep their values.
REQ-020 A rising edge with shift_cont = 1 and counter = 0 SHALL move the FSM to DONE; there SHALL be no counter wrap-around.
REQ-021 DONE SHALL last exactly one cycle and SHALL then return to IDLE unconditionally.
REQ-022 With no hold, shift_cont SHALL be high for exactly WIDTH consecutive cycles, starting the cycle after the start edge.
REQ-023 The downstream stage SHALL see bit i of each operand on the i-th rising edge at which shift_cont is high.
REQ-024 start = 1 in the DONE cycle SHALL be ignored, and the earliest new acceptance SHALL be at the first IDLE edge.
REQ-025 hold asserted in IDLE or DONE SHALL have no effect.

Reset
REQ-026 reset = 1 SHALL immediately force state to IDLE, clear both shift registers and the counter, and drive shift_cont, s_input_A, s_input, busy and done to 0.
REQ-027 reset asserted mid-burst SHALL abandon the burst with no done pulse, and operation SHALL resume only via a new start after reset is released.

Structure
REQ-028 The shared package serial_feed_pkg SHALL hold the state encoding (IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10) and the default WIDTH constant.
REQ-029 The bit counter SHALL be a sub-module down_counter with load, enable and zero-flag; width SHALL be clog2(WIDTH), with asynchronous active-high reset.
REQ-030 All other logic SHALL reside in serial_feed_ctrl, and its outputs SHALL be free of combinational paths from start or a_in/b_in.

Verification
REQ-031 Scenario basic: WIDTH = 4, a_in = 4'b0101, b_in = 4'b0011, start pulsed -> shift_cont high 4 cycles; s_input_A = 1,0,1,0; s_input = 1,1,0,0; done pulses once on the following cycle.
REQ-032 Scenario hold: same operands, hold = 1 during the 2nd shift cycle for 2 cycles -> shift_cont low for 2 cycles, outputs frozen at A = 0, B = 1, and exactly 4 total shift cycles.
REQ-033 Scenario ignored start: start held high through the whole burst -> no reload, busy stays high exactly 4 cycles, and the next burst begins only after the DONE cycle.
REQ-034 Scenario reset mid-burst: reset asserted asynchronously in the 3rd shift cycle -> all outputs 0 immediately, no done pulse, IDLE after release.
REQ-035 Scenario back-to-back: a_in = 4'b1111 / b_in = 4'b0000, then a_in = 4'b1000 / b_in = 4'b1001 -> second burst streams A = 0,0,0,1 and B = 1,0,0,1, starting one IDLE cycle after DONE.
REQ-036 Scenario WIDTH = 8: a_in = 8'hA5 -> 8 shift cycles with s_input_A = 1,0,1,0,0,1,0,1.

Source files
------------

// File: rtl/serial_feed_pkg.sv
// serial_feed_pkg: shared state encoding and default operand width for serial_feed_ctrl
package serial_feed_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SHIFT = 2'b01;
  localparam logic [1:0] DONE  = 2'b10;
endpackage

// File: rtl/down_counter.sv
// down_counter: loadable down counter that stops at zero and flags it
module down_counter #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] count;
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else count <= load ? load_val : (en && !zero) ? count - W'(1) : count;
  assign zero = count == '0;
endmodule

// File: rtl/serial_feed_ctrl.sv
// serial_feed_ctrl: loads two operands and streams them LSB first over a WIDTH-cycle shift burst
module serial_feed_ctrl
  import serial_feed_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             shift_cont,
  output logic             s_input_A,
  output logic             s_input,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state;
  logic [WIDTH-1:0] sr_a, sr_b;
  logic load, cnt_zero;
  assign load = state == IDLE && start;
  assign shift_cont = state == SHIFT && !hold;
  assign busy = state == SHIFT;
  assign done = state == DONE;
  // registers are emptied by the burst itself, so bit 0 already reads 0 back in IDLE
  assign s_input_A = sr_a[0];
  assign s_input = sr_b[0];
  down_counter #(.W(CW)) u_cnt (
    .clock(clock),
    .reset(reset),
    .load(load),
    .en(shift_cont),
    .load_val(CW'(WIDTH - 1)),
    .zero(cnt_zero)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      sr_a <= '0;
      sr_b <= '0;
    end else begin
      state <= load ? SHIFT : (shift_cont && cnt_zero) ? DONE : (state == SHIFT) ? SHIFT : IDLE;
      sr_a <= load ? a_in : shift_cont ? sr_a >> 1 : sr_a;
      sr_b <= load ? b_in : shift_cont ? sr_b >> 1 : sr_b;
    end
endmodule

// File: tb/tb_serial_feed_ctrl.sv
// tb_serial_feed_ctrl: directed vector table plus hand sequences for reset and WIDTH=8
module tb_serial_feed_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, hold = 1'b0;
  logic [3:0] a_in = '0, b_in = '0;
  logic shift_cont, s_input_A, s_input, busy, done;
  logic start8 = 1'b0, hold8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic sc8, sa8, sb8, busy8, done8;
  int tests = 0, fails = 0;

  always #5 clock = ~clock;

  serial_feed_ctrl u4 (
    .clock(clock), .reset(reset), .start(start), .hold(hold), .a_in(a_in), .b_in(b_in),
    .shift_cont(shift_cont), .s_input_A(s_input_A), .s_input(s_input), .busy(busy), .done(done)
  );
  serial_feed_ctrl #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(start8), .hold(hold8), .a_in(a8), .b_in(b8),
    .shift_cont(sc8), .s_input_A(sa8), .s_input(sb8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic s, h;
    logic [3:0] a, b;
    logic [4:0] e;
  } vec_t;
  vec_t vecs[29];

  function automatic vec_t mk(input logic s, h, input logic [3:0] a, b, input logic [4:0] e);
    vec_t v;
    v.s = s; v.h = h; v.a = a; v.b = b; v.e = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs4();
    return {shift_cont, s_input_A, s_input, busy, done};
  endfunction

  logic [7:0] a8val;
  int shifts;

  initial begin
    // {shift_cont, s_input_A, s_input, busy, done} seen in the cycle before the edge that consumes the inputs
    vecs[0]  = mk(1, 0, 4'b0101, 4'b0011, 5'b00000);
    vecs[1]  = mk(0, 0, 4'b0000, 4'b0000, 5'b11110);
    vecs[2]  = mk(0, 0, 4'b0000, 4'b0000, 5'b10110);
    vecs[3]  = mk(0, 0, 4'b0000, 4'b0000, 5'b11010);
    vecs[4]  = mk(0, 0, 4'b0000, 4'b0000, 5'b10010);
    vecs[5]  = mk(0, 0, 4'b0000, 4'b0000, 5'b00001);
    vecs[6]  = mk(0, 0, 4'b0000, 4'b0000, 5'b00000);
    vecs[7]  = mk(1, 0, 4'b0101, 4'b0011, 5'b00000);
    vecs[8]  = mk(0, 0, 4'b0000, 4'b0000, 5'b11110);
    vecs[9]  = mk(0, 1, 4'b0000, 4'b0000, 5'b00110);
    vecs[10] = mk(0, 1, 4'b0000, 4'b0000, 5'b00110);
    vecs[11] = mk(0, 0, 4'b0000, 4'b0000, 5'b10110);
    vecs[12] = mk(0, 0, 4'b0000, 4'b0000, 5'b11010);
    vecs[13] = mk(0, 0, 4'b0000, 4'b0000, 5'b10010);
    vecs[14] = mk(0, 1, 4'b0000, 4'b0000, 5'b00001);
    vecs[15] = mk(0, 1, 4'b0000, 4'b0000, 5'b00000);
    vecs[16] = mk(1, 0, 4'b1111, 4'b0000, 5'b00000);
    vecs[17] = mk(1, 0, 4'b0000, 4'b1111, 5'b11010);
    vecs[18] = mk(1, 0, 4'b0000, 4'b1111, 5'b11010);
    vecs[19] = mk(1, 0, 4'b0000, 4'b1111, 5'b11010);
    vecs[20] = mk(1, 0, 4'b0000, 4'b1111, 5'b11010);
    vecs[21] = mk(1, 0, 4'b0000, 4'b1111, 5'b00001);
    vecs[22] = mk(1, 0, 4'b1000, 4'b1001, 5'b00000);
    vecs[23] = mk(0, 0, 4'b0000, 4'b0000, 5'b10110);
    vecs[24] = mk(0, 0, 4'b0000, 4'b0000, 5'b10010);
    vecs[25] = mk(0, 0, 4'b0000, 4'b0000, 5'b10010);
    vecs[26] = mk(0, 0, 4'b0000, 4'b0000, 5'b11110);
    vecs[27] = mk(0, 0, 4'b0000, 4'b0000, 5'b00001);
    vecs[28] = mk(0, 0, 4'b0000, 4'b0000, 5'b00000);

    #1;
    chk("reset_outs4", 32'(outs4()), 32'h0);
    chk("reset_outs8", 32'({sc8, sa8, sb8, busy8, done8}), 32'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(negedge clock);
      start = vecs[i].s; hold = vecs[i].h; a_in = vecs[i].a; b_in = vecs[i].b;
      #1;
      chk($sformatf("row%0d", i), 32'(outs4()), 32'(vecs[i].e));
    end

    // reset in the 3rd shift cycle
    @(negedge clock);
    start = 1'b1; hold = 1'b0; a_in = 4'b0101; b_in = 4'b0011;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    chk("pre_reset_cycle3", 32'(outs4()), 32'(5'b11010));
    reset = 1'b1;
    #1;
    chk("async_reset_outs", 32'(outs4()), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      #1;
      chk($sformatf("post_reset_idle%0d", i), 32'(outs4()), 32'h0);
    end
    start = 1'b1; a_in = 4'b0011; b_in = 4'b0101;
    @(negedge clock);
    start = 1'b0;
    #1;
    chk("restart_after_reset", 32'(outs4()), 32'(5'b11110));

    // WIDTH=8 stream of A5
    a8val = 8'hA5;
    shifts = 0;
    @(negedge clock);
    start8 = 1'b1; a8 = a8val; b8 = 8'h3C;
    @(negedge clock);
    start8 = 1'b0; a8 = '0; b8 = '0;
    for (int i = 0; i < 8; i++) begin
      #1;
      shifts += int'(sc8);
      chk($sformatf("w8_bit%0d", i), 32'({sa8, busy8}), 32'({a8val[i], 1'b1}));
      @(negedge clock);
    end
    #1;
    chk("w8_shift_count", 32'(shifts), 32'd8);
    chk("w8_done", 32'({sc8, busy8, done8}), 32'(3'b001));
    @(negedge clock);
    #1;
    chk("w8_idle", 32'({sc8, busy8, done8}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
